snes_rst_sched: RTL and testbench
=================================

SNES_RST_SCHED -- requirements
Module: snes_rst_sched

Interface
REQ-001 SHALL provide parameter PULSE_LEN, default 24'd1_000_000, meaning the high time in CLK_i cycles of one reset pulse.
REQ-002 SHALL provide parameter GAP_LEN, default 24'd2_000_000, meaning the low time in cycles between the two pulses of a double reset.
REQ-003 SHALL provide parameter LONG_LEN, default 24'd8_000_000, meaning the high time in cycles of a long reset.
REQ-004 SHALL provide parameter COOL_LEN, default 24'd4_000_000, meaning the low time in cycles enforced after any reset activity before a new request is accepted.
REQ-005 All four length parameters SHALL be in the range 1..2^24-1.
REQ-006 CLK_i  input  1  system clock; all logic on its rising edge.
REQ-007 NRST_i  input  1  reset, asynchronous, active-low.
REQ-008 REQ_VALID_i  input  1  one-cycle strobe qualifying REQ_i.
REQ-009 REQ_i  input  2  request code: 01 soft, 10 double, 11 long, 00 none.
REQ-010 RST_BTN_i  input  1  front-panel reset button, asynchronous, active-high.
REQ-011 RST_o  output  1  registered console reset drive, active-high.
REQ-012 BUSY_o  output  1  high whenever the state is not IDLE.
REQ-013 REQ_DROP_o  output  1  one-cycle pulse when a valid nonzero request is rejected.

Function
REQ-014 RST_BTN_i SHALL pass through a 2-flop synchronizer; btn_s denotes its output.
REQ-015 The block SHALL have the states IDLE, PULSE1, GAP, PULSE2, LONG, BTN and COOL, driven by a 24-bit down-counter cnt.
REQ-016 On entry to a timed state, cnt SHALL be loaded with LEN-1 for that state; the state SHALL exit when cnt==0, so each timed state lasts exactly LEN cycles.
REQ-017 RST_o SHALL be 1 in PULSE1, PULSE2, LONG and BTN, and 0 in IDLE, GAP and COOL; it SHALL be registered, i.e. it reflects the state of the same cycle.
REQ-018 In IDLE, with REQ_VALID_i=1 and btn_s=0: REQ_i=01 or 10 SHALL go to PULSE1; REQ_i=11 SHALL go to LONG; REQ_i=00 SHALL be ignored without a drop pulse.
REQ-019 A request accepted at edge N SHALL produce RST_o=1 from cycle N+1.
REQ-020 The PULSE1 exit SHALL go to GAP for a double request and to COOL for a soft request; the request type SHALL be latched at acceptance.
REQ-021 GAP SHALL go to PULSE2 on exit; PULSE2 SHALL go to COOL; LONG SHALL go to COOL; COOL SHALL go to IDLE.
REQ-022 btn_s=1 SHALL force BTN from any state on the next edge, aborting any sequence in progress; this is the highest priority.
REQ-023 BTN SHALL hold while btn_s=1 and SHALL go to COOL on the first cycle with btn_s=0; BTN is untimed.
REQ-024 Any REQ_VALID_i=1 with nonzero REQ_i outside IDLE, or in IDLE in the same cycle as btn_s=1, SHALL be dropped: REQ_DROP_o=1 on the next cycle and no state effect.
REQ-025 Dropped requests SHALL NOT be queued.
REQ-026 BUSY_o SHALL be registered and equal to (state!=IDLE).
REQ-027 Counter arithmetic SHALL be unsigned 24-bit; cnt SHALL never underflow, because the zero test precedes the decrement.
REQ-028 LEN=1 SHALL yield a one-cycle state.

Reset
REQ-029 NRST_i low SHALL asynchronously force: state IDLE, cnt 0, latched type 0, synchronizer flops 0, RST_o 0, BUSY_o 0, REQ_DROP_o 0.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence immediately and drive RST_o low with no cooldown.
REQ-031 After release of NRST_i, the block SHALL accept a request on the first edge.

Verification (PULSE_LEN=4, GAP_LEN=3, LONG_LEN=10, COOL_LEN=5)
REQ-032 Soft: REQ_i=01 strobe in IDLE -> RST_o high for exactly 4 cycles starting the next cycle, then low with BUSY_o=1 for 5 cycles, then BUSY_o=0.
REQ-033 Double: REQ_i=10 -> RST_o sequence 1111 000 1111, then 5 cooldown cycles, 16 busy cycles in total.
REQ-034 Long plus drop: REQ_i=11, then a REQ_i=01 strobe 3 cycles later -> RST_o high for 10 cycles uninterrupted, REQ_DROP_o pulses once, and no second pulse follows.
REQ-035 Button preempt: assert RST_BTN_i during GAP of a double reset for 6 cycles -> RST_o=1 from sync latency+1 while held, no PULSE2, then 5 cooldown cycles, then IDLE.
REQ-036 Async reset: NRST_i low during LONG -> RST_o=0 and BUSY_o=0 without a clock edge; a REQ_i=01 strobe on the first edge after release is accepted.
REQ-037 Null code: REQ_i=00 strobe in IDLE -> no state change and REQ_DROP_o stays 0.

Source files
------------

// File: rtl/snes_rst_sched.sv
// Console reset scheduler: soft, double and long reset pulses on request, plus a
// front-panel button override. A cooldown follows all reset activity.
module snes_rst_sched #(
  parameter logic [23:0] PULSE_LEN = 24'd1_000_000,
  parameter logic [23:0] GAP_LEN   = 24'd2_000_000,
  parameter logic [23:0] LONG_LEN  = 24'd8_000_000,
  parameter logic [23:0] COOL_LEN  = 24'd4_000_000
) (
  input  logic       CLK_i,
  input  logic       NRST_i,
  input  logic       REQ_VALID_i,
  input  logic [1:0] REQ_i,
  input  logic       RST_BTN_i,
  output logic       RST_o,
  output logic       BUSY_o,
  output logic       REQ_DROP_o,
  output logic [2:0] STATE_DBG_o
);

  // Handshake: REQ_VALID_i is a one-cycle strobe with no ready. A nonzero code is
  // taken only in IDLE with the button released; otherwise it is dropped and
  // REQ_DROP_o pulses on the following cycle.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE1 = 3'd1,
    S_GAP    = 3'd2,
    S_PULSE2 = 3'd3,
    S_LONG   = 3'd4,
    S_BTN    = 3'd5,
    S_COOL   = 3'd6
  } state_t;

  localparam logic [23:0] PULSE_LD = PULSE_LEN - 24'd1;
  localparam logic [23:0] GAP_LD   = GAP_LEN - 24'd1;
  localparam logic [23:0] LONG_LD  = LONG_LEN - 24'd1;
  localparam logic [23:0] COOL_LD  = COOL_LEN - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        dbl_q, dbl_d;
  logic        btn_meta_q, btn_meta_d;
  logic        btn_s_q, btn_s_d;
  logic        rst_q, rst_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;

  logic        req_nz;
  logic        cnt_zero;
  logic [23:0] cnt_dec;

  assign req_nz   = REQ_VALID_i && (REQ_i != 2'b00);
  assign cnt_zero = (cnt_q == 24'd0);
  assign cnt_dec  = cnt_q - 24'd1;

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 24'd0;
      dbl_q      <= 1'b0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      rst_q      <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dbl_q      <= dbl_d;
      btn_meta_q <= btn_meta_d;
      btn_s_q    <= btn_s_d;
      rst_q      <= rst_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  // The zero test comes before the decrement, so a state loaded with LEN-1 lasts
  // exactly LEN cycles and the counter never wraps.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dbl_d      = dbl_q;
    btn_meta_d = RST_BTN_i;
    btn_s_d    = btn_meta_q;
    if (btn_s_q) begin
      state_d = S_BTN;
      cnt_d   = 24'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_nz) begin
            if (REQ_i == 2'b11) begin
              state_d = S_LONG;
              cnt_d   = LONG_LD;
            end else begin
              state_d = S_PULSE1;
              cnt_d   = PULSE_LD;
              dbl_d   = (REQ_i == 2'b10);
            end
          end
        end
        S_PULSE1: begin
          if (!cnt_zero) begin
            cnt_d = cnt_dec;
          end else if (dbl_q) begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = S_COOL;
            cnt_d   = COOL_LD;
          end
        end
        S_GAP: begin
          if (!cnt_zero) begin
            cnt_d = cnt_dec;
          end else begin
            state_d = S_PULSE2;
            cnt_d   = PULSE_LD;
          end
        end
        S_PULSE2, S_LONG: begin
          if (!cnt_zero) begin
            cnt_d = cnt_dec;
          end else begin
            state_d = S_COOL;
            cnt_d   = COOL_LD;
          end
        end
        S_BTN: begin
          state_d = S_COOL;
          cnt_d   = COOL_LD;
        end
        S_COOL: begin
          if (!cnt_zero) begin
            cnt_d = cnt_dec;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 24'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with
  // the state they describe.
  always_comb begin
    rst_d  = (state_d == S_PULSE1) || (state_d == S_PULSE2) ||
             (state_d == S_LONG) || (state_d == S_BTN);
    busy_d = (state_d != S_IDLE);
    drop_d = req_nz && ((state_q != S_IDLE) || btn_s_q);
  end

  assign RST_o       = rst_q;
  assign BUSY_o      = busy_q;
  assign REQ_DROP_o  = drop_q;
  assign STATE_DBG_o = state_q;

endmodule

// File: tb/tb_snes_rst_sched.sv
// Bench for snes_rst_sched: a schedule-queue model checked every cycle, plus
// literal per-scenario waveforms for RST_o, BUSY_o and REQ_DROP_o.
module tb_snes_rst_sched;

  localparam int P = 4;
  localparam int G = 3;
  localparam int L = 10;
  localparam int C = 5;

  logic       clk;
  logic       nrst;
  logic       valid;
  logic [1:0] req;
  logic       btn;
  logic       rst_o;
  logic       busy_o;
  logic       drop_o;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  snes_rst_sched #(
    .PULSE_LEN(24'd4),
    .GAP_LEN  (24'd3),
    .LONG_LEN (24'd10),
    .COOL_LEN (24'd5)
  ) dut (
    .CLK_i      (clk),
    .NRST_i     (nrst),
    .REQ_VALID_i(valid),
    .REQ_i      (req),
    .RST_BTN_i  (btn),
    .RST_o      (rst_o),
    .BUSY_o     (busy_o),
    .REQ_DROP_o (drop_o),
    .STATE_DBG_o(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of planned {rst,busy} values, one entry per future cycle.
  logic [1:0] exp_q[$];
  bit m_rst, m_busy, m_drop, m_in_btn, m_sa, m_sb;

  function automatic void push_run(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({v, 1'b1});
  endfunction

  always @(posedge clk or negedge nrst) begin
    bit was_busy;
    bit nz;
    if (!nrst) begin
      exp_q.delete();
      m_rst = 0; m_busy = 0; m_drop = 0; m_in_btn = 0; m_sa = 0; m_sb = 0;
    end else begin
      was_busy = m_busy;
      nz       = valid && (req != 2'b00);
      m_drop   = nz && (was_busy || m_sb);
      if (m_sb) begin
        exp_q.delete();
        m_in_btn = 1;
        m_rst    = 1;
        m_busy   = 1;
      end else begin
        if (m_in_btn) begin
          m_in_btn = 0;
          push_run(0, C);
        end else if (!was_busy && nz) begin
          if (req == 2'b11) begin
            push_run(1, L);
          end else begin
            push_run(1, P);
            if (req == 2'b10) begin
              push_run(0, G);
              push_run(1, P);
            end
          end
          push_run(0, C);
        end
        if (exp_q.size() > 0) {m_rst, m_busy} = exp_q.pop_front();
        else {m_rst, m_busy} = 2'b00;
      end
      m_sb = m_sa;
      m_sa = btn;
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rst", {31'd0, rst_o}, {31'd0, m_rst});
      chk("model_busy", {31'd0, busy_o}, {31'd0, m_busy});
      chk("model_drop", {31'd0, drop_o}, {31'd0, m_drop});
    end
  end

  // Drivers
  task automatic strobe(input logic [1:0] code);
    @(posedge clk); #1;
    valid = 1'b1; req = code;
    @(posedge clk); #1;
    valid = 1'b0; req = 2'b00;
  endtask

  // Records n cycles of outputs (first cycle in the MSB) while optionally
  // injecting one request at cycle inj_at and holding the button over [b0,b1).
  task automatic rec(input int n, input int inj_at, input logic [1:0] code,
                     input int b0, input int b1,
                     output logic [31:0] r, output logic [31:0] bz, output logic [31:0] dr);
    r = 0; bz = 0; dr = 0;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      valid = (i == inj_at);
      req   = (i == inj_at) ? code : 2'b00;
      btn   = (i >= b0) && (i < b1);
      if (i == n) break;
      @(negedge clk);
      r  = {r[30:0], rst_o};
      bz = {bz[30:0], busy_o};
      dr = {dr[30:0], drop_o};
    end
    valid = 1'b0; req = 2'b00; btn = 1'b0;
  endtask

  logic [31:0] r, bz, dr;

  initial begin
    nrst = 1'b0; valid = 1'b0; req = 2'b00; btn = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rst", {31'd0, rst_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_drop", {31'd0, drop_o}, 32'd0);
    @(negedge clk); #2 nrst = 1'b1;

    // Soft reset
    strobe(2'b01);
    rec(10, -1, 2'b00, -1, -1, r, bz, dr);
    chk("soft_rst", r, 32'b1111000000);
    chk("soft_busy", bz, 32'b1111111110);
    chk("soft_drop", dr, 32'd0);

    // Double reset
    strobe(2'b10);
    rec(18, -1, 2'b00, -1, -1, r, bz, dr);
    chk("double_rst", r, 32'b111100011110000000);
    chk("double_busy", bz, 32'b111111111111111100);
    chk("double_drop", dr, 32'd0);

    // Long reset with a soft request arriving mid-pulse
    strobe(2'b11);
    rec(17, 2, 2'b01, -1, -1, r, bz, dr);
    chk("long_rst", r, 32'b11111111110000000);
    chk("long_busy", bz, 32'b11111111111111100);
    chk("long_drop", dr, 32'b00010000000000000);

    // Button held during the gap of a double reset
    strobe(2'b10);
    rec(20, -1, 2'b00, 4, 10, r, bz, dr);
    chk("btn_rst", r, 32'b11110001111110000000);
    chk("btn_busy", bz, 32'b11111111111111111100);
    chk("btn_drop", dr, 32'd0);

    // Button from idle, with a request colliding with the synchronized button
    @(posedge clk); #1;
    rec(14, 3, 2'b01, 0, 4, r, bz, dr);
    chk("idlebtn_rst", r, 32'b00011110000000);
    chk("idlebtn_busy", bz, 32'b00011111111100);
    chk("idlebtn_drop", dr, 32'b00001000000000);

    // Null code
    strobe(2'b00);
    rec(3, -1, 2'b00, -1, -1, r, bz, dr);
    chk("null_rst", r, 32'd0);
    chk("null_busy", bz, 32'd0);
    chk("null_drop", dr, 32'd0);

    // Asynchronous reset during a long pulse, then a request on the first edge
    strobe(2'b11);
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst", {31'd0, rst_o}, 32'd0);
    chk("async_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk); #2;
    nrst = 1'b1; valid = 1'b1; req = 2'b01;
    @(posedge clk); #1;
    valid = 1'b0; req = 2'b00;
    @(negedge clk);
    chk("release_accept_rst", {31'd0, rst_o}, 32'd1);
    chk("release_accept_busy", {31'd0, busy_o}, 32'd1);
    repeat (12) @(negedge clk);
    chk("final_idle_busy", {31'd0, busy_o}, 32'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
